// File: rtl/epd_timing_gen_if.sv
// epd_timing_gen_if: pixel-word stream from memif into the EPD timing generator.
// The source drives data/valid; the timing generator drives ready.
interface epd_timing_gen_if #(
   parameter int SD_WIDTH = 16
);
   logic [SD_WIDTH-1:0] pix_data;
   logic                pix_valid;
   logic                pix_ready;

   modport master (
      output pix_data,
      output pix_valid,
      input  pix_ready
   );

   modport slave (
      input  pix_data,
      input  pix_valid,
      output pix_ready
   );
endinterface

// File: rtl/epd_timing_gen.sv
// epd_timing_gen: EPD gate/source driver timing from a pixel stream.
// div/h/v position counters with every panel pin registered from the next position.
module epd_timing_gen #(
   parameter int SD_WIDTH = 16,
   parameter int CLK_DIV  = 1,
   parameter int H_SYNC   = 1,
   parameter int H_BP     = 2,
   parameter int H_ACTIVE = 400,
   parameter int H_FP     = 4,
   parameter int V_SYNC   = 1,
   parameter int V_BP     = 2,
   parameter int V_ACTIVE = 1200,
   parameter int V_FP     = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic [7:0]          frames,
   epd_timing_gen_if.slave     pix,
   output logic                vsync,
   output logic                frame_done,
   output logic                busy,
   output logic                underflow,
   output logic                epd_gdoe,
   output logic                epd_gdclk,
   output logic                epd_gdsp,
   output logic                epd_sdclk,
   output logic                epd_sdle,
   output logic                epd_sdoe,
   output logic [SD_WIDTH-1:0] epd_sd,
   output logic                epd_sdce0
);

   localparam int DIV_N   = 2 * CLK_DIV;
   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int DIV_W   = (DIV_N > 1) ? $clog2(DIV_N) : 1;
   localparam int H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
   localparam int HA0     = H_SYNC + H_BP;
   localparam int HA1     = HA0 + H_ACTIVE;
   localparam int VA0     = V_SYNC + V_BP;
   localparam int VA1     = VA0 + V_ACTIVE;

   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV_N - 1);
   localparam logic [H_W-1:0]   H_MAX   = H_W'(H_TOTAL - 1);
   localparam logic [V_W-1:0]   V_MAX   = V_W'(V_TOTAL - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] div;
   logic [H_W-1:0]   h;
   logic [V_W-1:0]   v;
   logic [7:0]       frames_left;
   logic             cont;
   logic             stop_pend;

   logic [DIV_W-1:0] nd;
   logic [H_W-1:0]   nh;
   logic [V_W-1:0]   nv;
   logic [H_W-1:0]   th;
   logic [V_W-1:0]   tv;
   logic             div_wrap;
   logic             h_wrap;
   logic             v_wrap;
   logic             frame_end;
   logic             launch;
   logic             finish;
   logic             active;
   logic             n_data;
   logic             n_ready;
   logic             n_first;
   logic             n_last;
   logic             took;

   function automatic logic in_data(
      input logic [H_W-1:0] hh,
      input logic [V_W-1:0] vv
   );
      return int'(hh) >= HA0 && int'(hh) < HA1 &&
             int'(vv) >= VA0 && int'(vv) < VA1;
   endfunction

   // Position the registered outputs will describe after this edge,
   // plus the tick after it (needed one tick early for pix_ready).
   always_comb begin
      div_wrap  = div == DIV_MAX;
      h_wrap    = h == H_MAX;
      v_wrap    = v == V_MAX;
      frame_end = div_wrap && h_wrap && v_wrap;
      nd = '0;
      nh = '0;
      nv = '0;
      if (state == RUN) begin
         nd = div_wrap ? '0 : div + DIV_W'(1);
         nh = h;
         nv = v;
         if (div_wrap) begin
            nh = h_wrap ? '0 : h + H_W'(1);
            if (h_wrap) begin
               nv = v_wrap ? '0 : v + V_W'(1);
            end
         end
      end
      th = (nh == H_MAX) ? '0 : nh + H_W'(1);
      tv = nv;
      if (nh == H_MAX) begin
         tv = (nv == V_MAX) ? '0 : nv + V_W'(1);
      end
      n_data  = in_data(nh, nv);
      n_ready = (nd == DIV_MAX) && in_data(th, tv);
      n_first = (nd == '0) && (nh == '0) && (nv == '0);
      n_last  = (nd == DIV_MAX) && (nh == H_MAX) && (nv == V_MAX);
      launch  = (state == IDLE) && start;
      finish  = (state == RUN) && frame_end &&
                (stop_pend || stop ||
                 (!cont && frames_left == 8'd1));
      active  = launch || ((state == RUN) && !finish);
      took    = pix.pix_ready && pix.pix_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         div           <= '0;
         h             <= '0;
         v             <= '0;
         frames_left   <= '0;
         cont          <= 1'b0;
         stop_pend     <= 1'b0;
         busy          <= 1'b0;
         vsync         <= 1'b0;
         frame_done    <= 1'b0;
         underflow     <= 1'b0;
         pix.pix_ready <= 1'b0;
         epd_gdoe      <= 1'b0;
         epd_gdclk     <= 1'b0;
         epd_gdsp      <= 1'b1;
         epd_sdclk     <= 1'b0;
         epd_sdle      <= 1'b0;
         epd_sdoe      <= 1'b0;
         epd_sd        <= '0;
         epd_sdce0     <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (launch) begin
                  state       <= RUN;
                  frames_left <= frames;
                  cont        <= frames == 8'd0;
                  stop_pend   <= 1'b0;
               end
            end
            RUN: begin
               if (stop) begin
                  stop_pend <= 1'b1;
               end
               if (frame_end) begin
                  if (finish) begin
                     state <= IDLE;
                  end else if (!cont) begin
                     frames_left <= frames_left - 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (active) begin
            div           <= nd;
            h             <= nh;
            v             <= nv;
            busy          <= 1'b1;
            vsync         <= n_first;
            frame_done    <= n_last;
            pix.pix_ready <= n_ready;
            epd_gdoe      <= 1'b1;
            epd_sdoe      <= 1'b1;
            epd_sdclk     <= int'(nd) >= CLK_DIV;
            epd_sdle      <= int'(nh) < H_SYNC;
            epd_gdclk     <= int'(nh) < (H_TOTAL / 2);
            epd_gdsp      <= int'(nv) >= V_SYNC;
            epd_sdce0     <= !n_data;
            // New word only at the sdclk falling boundary of a data tick.
            if (!n_data) begin
               epd_sd <= '0;
            end else if (nd == '0) begin
               epd_sd <= took ? pix.pix_data : '0;
            end
            if (launch) begin
               underflow <= 1'b0;
            end else if (n_data && nd == '0 && !took) begin
               underflow <= 1'b1;
            end
         end else begin
            div           <= '0;
            h             <= '0;
            v             <= '0;
            busy          <= 1'b0;
            vsync         <= 1'b0;
            frame_done    <= 1'b0;
            pix.pix_ready <= 1'b0;
            epd_gdoe      <= 1'b0;
            epd_gdclk     <= 1'b0;
            epd_gdsp      <= 1'b1;
            epd_sdclk     <= 1'b0;
            epd_sdle      <= 1'b0;
            epd_sdoe      <= 1'b0;
            epd_sd        <= '0;
            epd_sdce0     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_epd_timing_gen.sv
// tb_epd_timing_gen: table vectors, directed frame runs and random runs
// checked against an arithmetic per-clock model of the panel waveform.
module tb_epd_timing_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stop;
   logic [7:0]  frames;
   logic        vsync;
   logic        frame_done;
   logic        busy;
   logic        underflow;
   logic        gdoe;
   logic        gdclk;
   logic        gdsp;
   logic        sdclk;
   logic        sdle;
   logic        sdoe;
   logic [15:0] sd;
   logic        sdce0;

   int n_tests = 0;
   int n_fail  = 0;

   epd_timing_gen_if #(.SD_WIDTH(16)) pix ();

   epd_timing_gen #(
      .SD_WIDTH(16), .CLK_DIV(1),
      .H_SYNC(1), .H_BP(1), .H_ACTIVE(4), .H_FP(2),
      .V_SYNC(1), .V_BP(1), .V_ACTIVE(2), .V_FP(1)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .frames(frames), .pix(pix), .vsync(vsync),
      .frame_done(frame_done), .busy(busy), .underflow(underflow),
      .epd_gdoe(gdoe), .epd_gdclk(gdclk), .epd_gdsp(gdsp),
      .epd_sdclk(sdclk), .epd_sdle(sdle), .epd_sdoe(sdoe),
      .epd_sd(sd), .epd_sdce0(sdce0)
   );

   always #5 clk = ~clk;

   logic [31:0] dv;
   assign dv = {4'b0, busy, vsync, frame_done, pix.pix_ready,
                gdoe, gdclk, gdsp, sdclk, sdle, sdoe, sdce0,
                underflow, sd};

   typedef struct {
      logic       rst;
      logic       start;
      logic       stop;
      logic       pv;
      logic [7:0] frames;
      logic [9:0] exp;
   } vec_t;

   vec_t tbl [7];

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // 80-clk frame: tick = k/2, line = tick/8, column = tick%8.
   function automatic bit is_data(input int tick);
      int t;
      int hh;
      int vv;
      t  = tick % 40;
      hh = t % 8;
      vv = t / 8;
      return hh >= 2 && hh < 6 && vv >= 2 && vv < 4;
   endfunction

   function automatic logic [31:0] exp_vec(input int k,
                                           input logic [15:0] word,
                                           input logic uf);
      int  tick;
      int  hh;
      int  vv;
      bit  d;
      if (k < 0) begin
         return {4'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                 1'b0, 1'b1, uf, 16'h0};
      end
      tick = k / 2;
      hh   = tick % 8;
      vv   = tick / 8;
      d    = is_data(tick);
      return {4'b0, 1'b1, k == 0, k == 79,
              (k % 2 == 1) && is_data(tick + 1),
              1'b1, hh < 4, vv >= 1, k % 2 == 1, hh < 1, 1'b1,
              !d, uf, d ? word : 16'h0};
   endfunction

   task automatic run(input int nfr, input int stop_at,
                      input int drop_hs, input bit rnd,
                      input int rst_at, input int start_at,
                      output int hs_cnt);
      int          nf;
      int          opp;
      int          k;
      logic [15:0] word;
      logic [15:0] nxt;
      logic        uf;
      logic        vld;
      bit          rdy;
      hs_cnt = 0;
      opp    = 0;
      word   = 16'h0;
      nxt    = 16'h0001;
      uf     = 1'b0;
      nf     = (nfr == 0) ? 1000 : nfr;
      if (stop_at >= 0 && stop_at / 80 + 1 < nf) nf = stop_at / 80 + 1;
      frames = 8'(nfr);
      start  = 1'b1;
      cycle();
      start  = 1'b0;
      frames = 8'($urandom);
      for (int cyc = 0; cyc < nf * 80; cyc++) begin
         k = cyc % 80;
         chk("run", dv, exp_vec(k, word, uf));
         if (cyc == rst_at) begin
            rst = 1'b1;
            cycle();
            rst = 1'b0;
            chk("rst", dv, exp_vec(-1, 16'h0, 1'b0));
            return;
         end
         rdy = (k % 2 == 1) && is_data(k / 2 + 1);
         vld = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (rdy && opp == drop_hs) vld = 1'b0;
         pix.pix_valid = vld;
         pix.pix_data  = rnd ? 16'($urandom) : nxt;
         stop  = cyc == stop_at;
         start = cyc == start_at;
         if (rdy) begin
            opp++;
            if (vld) begin
               word = pix.pix_data;
               nxt  = nxt + 16'h0001;
               hs_cnt++;
            end else begin
               word = 16'h0;
               uf   = 1'b1;
            end
         end
         cycle();
      end
      start = 1'b0;
      stop  = 1'b0;
      pix.pix_valid = 1'b0;
      chk("end", dv, exp_vec(-1, 16'h0, uf));
   endtask

   initial begin
      int hs;
      int nfr;
      int sa;
      rst   = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      frames = 8'd0;
      pix.pix_valid = 1'b0;
      pix.pix_data  = 16'h0;
      cycle();
      cycle();
      rst = 1'b0;
      chk("reset", dv, exp_vec(-1, 16'h0, 1'b0));

      // {busy,vsync,sdclk,sdle,gdclk,gdsp,gdoe,sdoe,sdce0,pix_ready}
      tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 10'b0000010010};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 10'b1101101110};
      tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 10'b1011101110};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd5, 10'b1000101110};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 10'b1010101110};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 10'b0000010010};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 10'b0000010010};
      for (int i = 0; i < 7; i++) begin
         rst    = tbl[i].rst;
         start  = tbl[i].start;
         stop   = tbl[i].stop;
         frames = tbl[i].frames;
         pix.pix_valid = tbl[i].pv;
         cycle();
         chk($sformatf("tbl%0d", i),
             32'({busy, vsync, sdclk, sdle, gdclk, gdsp, gdoe,
                  sdoe, sdce0, pix.pix_ready}),
             32'(tbl[i].exp));
      end
      rst = 1'b0;
      start = 1'b0;
      stop = 1'b0;
      pix.pix_valid = 1'b0;

      run(1, -1, -1, 1'b0, -1, -1, hs);
      chk("one_frame_hs", hs, 8);

      run(3, -1, -1, 1'b0, -1, 50, hs);
      chk("three_frame_hs", hs, 24);

      run(0, 99, -1, 1'b0, -1, -1, hs);
      chk("cont_stop_hs", hs, 16);

      run(0, 79, -1, 1'b0, -1, -1, hs);
      chk("stop_on_done_hs", hs, 8);

      run(1, -1, 2, 1'b0, -1, -1, hs);
      chk("drop_hs", hs, 7);
      for (int i = 0; i < 3; i++) begin
         stop = 1'b1;
         cycle();
         chk("uf_sticky", 32'(underflow), 32'd1);
      end
      stop = 1'b0;

      run(1, -1, -1, 1'b0, 36, -1, hs);
      run(1, -1, -1, 1'b0, -1, -1, hs);
      chk("after_rst_hs", hs, 8);

      for (int i = 0; i < 8; i++) begin
         nfr = $urandom_range(0, 3);
         sa  = -1;
         if (nfr == 0 || $urandom_range(0, 1) == 1) begin
            sa = $urandom_range(0, ((nfr == 0) ? 3 : nfr) * 80 - 1);
         end
         run(nfr, sa, -1, 1'b1, -1, $urandom_range(1, 70), hs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
